mem_port_arbiter: RTL and testbench

// - Shares the single cache-line memory port to the AXI bridge among three requesters: icache (read), dcache (read/write) and uncache (read/write).
// - Sits between the cache/uncache units and the AXI bridge.
// - Owner-tracked read and write FSMs route each return to the requester that issued the request.

---
 rtl/mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single cache-line memory port of the AXI bridge among the
// icache (read only), dcache (read/write) and uncache (read/write) units.
// Independent read and write FSMs each keep one transaction outstanding and
// remember the owner so that returns and grants are routed correctly.
//
// Build option: define ARB_RAW_CHECK_EN to hold back icache/dcache reads that
// hit the 32-byte line of the write currently in flight. Without it, reads
// are eligible regardless of write activity.
//
// Read FSM states
//   RIDLE | no read outstanding, arbitrating
//   RREQ  | m_rd_req driven, waiting for m_rd_rdy
//   RRESP | routing return beats to the owner until m_ret_last
// Write FSM states
//   WIDLE | no write outstanding, arbitrating
//   WREQ  | m_wr_req driven, waiting for m_wr_rdy
//   WRESP | waiting for m_wr_done
module mem_port_arbiter #(
    parameter int LINE_W     = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic              i_rd_req,
    input  logic [2:0]        i_rd_type,
    input  logic [31:0]       i_rd_addr,
    output logic              i_rd_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_last,

    input  logic              d_rd_req,
    input  logic [2:0]        d_rd_type,
    input  logic [31:0]       d_rd_addr,
    output logic              d_rd_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_last,

    input  logic              u_rd_req,
    input  logic [2:0]        u_rd_type,
    input  logic [31:0]       u_rd_addr,
    output logic              u_rd_rdy,
    output logic              u_ret_valid,
    output logic              u_ret_last,

    output logic [31:0]       ret_data,

    input  logic              d_wr_req,
    input  logic [2:0]        d_wr_type,
    input  logic [31:0]       d_wr_addr,
    input  logic [3:0]        d_wr_wstrb,
    input  logic [LINE_W-1:0] d_wr_data,
    output logic              d_wr_rdy,

    input  logic              u_wr_req,
    input  logic [2:0]        u_wr_type,
    input  logic [31:0]       u_wr_addr,
    input  logic [3:0]        u_wr_wstrb,
    input  logic [LINE_W-1:0] u_wr_data,
    output logic              u_wr_rdy,

    output logic              m_rd_req,
    output logic [2:0]        m_rd_type,
    output logic [31:0]       m_rd_addr,
    input  logic              m_rd_rdy,
    input  logic              m_ret_valid,
    input  logic              m_ret_last,
    input  logic [31:0]       m_ret_data,

    output logic              m_wr_req,
    output logic [2:0]        m_wr_type,
    output logic [31:0]       m_wr_addr,
    output logic [3:0]        m_wr_wstrb,
    output logic [LINE_W-1:0] m_wr_data,
    input  logic              m_wr_rdy,
    input  logic              m_wr_done
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {RIDLE, RREQ, RRESP} rd_state_t;
    typedef enum logic [1:0] {WIDLE, WREQ, WRESP} wr_state_t;
    typedef enum logic [1:0] {OWN_I, OWN_D, OWN_U} rd_owner_t;
    typedef enum logic       {WOWN_D, WOWN_U}      wr_owner_t;

    rd_state_t   rd_state;
    rd_owner_t   rd_owner;
    wr_state_t   wr_state;
    wr_owner_t   wr_owner;
    logic [SW-1:0] starve_cnt;

    logic        wr_busy;
    logic        u_blocked;
    logic        i_hazard;
    logic        d_hazard;
    logic        i_ok;
    logic        d_ok;
    logic        u_ok;
    logic        rgnt_i;
    logic        rgnt_d;
    logic        rgnt_u;
    logic        wgnt_d;
    logic        wgnt_u;
    logic [2:0]  rsel_type;
    logic [31:0] rsel_addr;
    logic [2:0]  wsel_type;
    logic [31:0] wsel_addr;
    logic [3:0]  wsel_wstrb;
    logic [LINE_W-1:0] wsel_data;
    logic        in_resp;

    // Only the low word of an uncache write carries data.
    logic        unused_u_wr_hi;
    assign unused_u_wr_hi = ^u_wr_data[LINE_W-1:32];

    // Read eligibility and grant: u > d > i, icache forced once starved.
    // Grants are suppressed while reset is asserted so every rdy reads 0.
    always_comb begin
        wr_busy   = (wr_state != WIDLE);
        u_blocked = wr_busy && (wr_owner == WOWN_U);
        i_hazard  = 1'b0;
        d_hazard  = 1'b0;
`ifdef ARB_RAW_CHECK_EN
        i_hazard  = wr_busy && (i_rd_addr[31:5] == m_wr_addr[31:5]);
        d_hazard  = wr_busy && (d_rd_addr[31:5] == m_wr_addr[31:5]);
`endif
        i_ok = i_rd_req && !i_hazard;
        d_ok = d_rd_req && !d_hazard;
        u_ok = u_rd_req && !u_blocked;

        rgnt_i = 1'b0;
        rgnt_d = 1'b0;
        rgnt_u = 1'b0;
        if (aresetn && (rd_state == RIDLE)) begin
            if (i_ok && (starve_cnt == STARVE_LIM)) begin
                rgnt_i = 1'b1;
            end else if (u_ok) begin
                rgnt_u = 1'b1;
            end else if (d_ok) begin
                rgnt_d = 1'b1;
            end else if (i_ok) begin
                rgnt_i = 1'b1;
            end
        end
    end

    // Write grant: uncache over dcache, one write in flight.
    always_comb begin
        wgnt_u = aresetn && (wr_state == WIDLE) && u_wr_req;
        wgnt_d = aresetn && (wr_state == WIDLE) && d_wr_req && !u_wr_req;
    end

    assign i_rd_rdy = rgnt_i;
    assign d_rd_rdy = rgnt_d;
    assign u_rd_rdy = rgnt_u;
    assign d_wr_rdy = wgnt_d;
    assign u_wr_rdy = wgnt_u;

    // Select the request fields of the read winner.
    always_comb begin
        rsel_type = i_rd_type;
        rsel_addr = i_rd_addr;
        if (rgnt_u) begin
            rsel_type = u_rd_type;
            rsel_addr = u_rd_addr;
        end else if (rgnt_d) begin
            rsel_type = d_rd_type;
            rsel_addr = d_rd_addr;
        end
    end

    // Select the request fields of the write winner; uncache data is zero-extended.
    always_comb begin
        wsel_type  = d_wr_type;
        wsel_addr  = d_wr_addr;
        wsel_wstrb = d_wr_wstrb;
        wsel_data  = d_wr_data;
        if (wgnt_u) begin
            wsel_type  = u_wr_type;
            wsel_addr  = u_wr_addr;
            wsel_wstrb = u_wr_wstrb;
            wsel_data  = {{(LINE_W-32){1'b0}}, u_wr_data[31:0]};
        end
    end

    // Read FSM: capture the winner, present it to the bridge, track the response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state  <= RIDLE;
            rd_owner  <= OWN_I;
            m_rd_req  <= 1'b0;
            m_rd_type <= '0;
            m_rd_addr <= '0;
        end else begin
            case (rd_state)
                RIDLE: begin
                    if (rgnt_i || rgnt_d || rgnt_u) begin
                        rd_state  <= RREQ;
                        m_rd_req  <= 1'b1;
                        m_rd_type <= rsel_type;
                        m_rd_addr <= rsel_addr;
                        if (rgnt_u) begin
                            rd_owner <= OWN_U;
                        end else if (rgnt_d) begin
                            rd_owner <= OWN_D;
                        end else begin
                            rd_owner <= OWN_I;
                        end
                    end
                end
                RREQ: begin
                    if (m_rd_rdy) begin
                        m_rd_req <= 1'b0;
                        rd_state <= RRESP;
                    end
                end
                RRESP: begin
                    if (m_ret_valid && m_ret_last) begin
                        rd_state <= RIDLE;
                    end
                end
                default: begin
                    rd_state <= RIDLE;
                    m_rd_req <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: data-side read grants seen while icache keeps waiting.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            starve_cnt <= '0;
        end else if (!i_rd_req || rgnt_i) begin
            starve_cnt <= '0;
        end else if ((rgnt_d || rgnt_u) && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Return routing: only the owner sees the bridge beats while in RRESP.
    always_comb begin
        in_resp     = (rd_state == RRESP);
        i_ret_valid = in_resp && (rd_owner == OWN_I) && m_ret_valid;
        d_ret_valid = in_resp && (rd_owner == OWN_D) && m_ret_valid;
        u_ret_valid = in_resp && (rd_owner == OWN_U) && m_ret_valid;
        i_ret_last  = i_ret_valid && m_ret_last;
        d_ret_last  = d_ret_valid && m_ret_last;
        u_ret_last  = u_ret_valid && m_ret_last;
        ret_data    = in_resp ? m_ret_data : 32'h0;
    end

    // Write FSM: capture the winner, hold the request, wait for the B response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state   <= WIDLE;
            wr_owner   <= WOWN_D;
            m_wr_req   <= 1'b0;
            m_wr_type  <= '0;
            m_wr_addr  <= '0;
            m_wr_wstrb <= '0;
            m_wr_data  <= '0;
        end else begin
            case (wr_state)
                WIDLE: begin
                    if (wgnt_u || wgnt_d) begin
                        wr_state   <= WREQ;
                        wr_owner   <= wgnt_u ? WOWN_U : WOWN_D;
                        m_wr_req   <= 1'b1;
                        m_wr_type  <= wsel_type;
                        m_wr_addr  <= wsel_addr;
                        m_wr_wstrb <= wsel_wstrb;
                        m_wr_data  <= wsel_data;
                    end
                end
                WREQ: begin
                    if (m_wr_rdy) begin
                        m_wr_req <= 1'b0;
                        wr_state <= WRESP;
                    end
                end
                WRESP: begin
                    if (m_wr_done) begin
                        wr_state <= WIDLE;
                    end
                end
                default: begin
                    wr_state <= WIDLE;
                    m_wr_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Random requesters and a random bridge drive the arbiter. A reference model
// tracks outstanding read/write transactions and the icache wait count and
// predicts grants, bridge requests and return routing each cycle; granted
// requests and bridge beats go into queues that a negedge monitor drains.
module tb_mem_port_arbiter;

    localparam int LINE_W     = 256;
    localparam int STARVE_MAX = 4;
`ifdef ARB_RAW_CHECK_EN
    localparam bit RAW_EN = 1'b1;
`else
    localparam bit RAW_EN = 1'b0;
`endif

    logic aclk;
    logic aresetn;

    // requester index: 0 i_rd, 1 d_rd, 2 u_rd, 3 d_wr, 4 u_wr
    logic              rq_req   [5];
    logic [2:0]        rq_type  [5];
    logic [31:0]       rq_addr  [5];
    logic [3:0]        rq_wstrb [5];
    logic [LINE_W-1:0] rq_data  [5];
    logic              gnt_seen [5];

    logic i_rd_rdy, i_ret_valid, i_ret_last;
    logic d_rd_rdy, d_ret_valid, d_ret_last;
    logic u_rd_rdy, u_ret_valid, u_ret_last;
    logic [31:0] ret_data;
    logic d_wr_rdy, u_wr_rdy;
    logic m_rd_req;
    logic [2:0] m_rd_type;
    logic [31:0] m_rd_addr;
    logic m_rd_rdy, m_ret_valid, m_ret_last;
    logic [31:0] m_ret_data;
    logic m_wr_req;
    logic [2:0] m_wr_type;
    logic [31:0] m_wr_addr;
    logic [3:0] m_wr_wstrb;
    logic [LINE_W-1:0] m_wr_data;
    logic m_wr_rdy, m_wr_done;

    mem_port_arbiter #(.LINE_W(LINE_W), .STARVE_MAX(STARVE_MAX)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_rd_req(rq_req[0]), .i_rd_type(rq_type[0]), .i_rd_addr(rq_addr[0]),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .d_rd_req(rq_req[1]), .d_rd_type(rq_type[1]), .d_rd_addr(rq_addr[1]),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .u_rd_req(rq_req[2]), .u_rd_type(rq_type[2]), .u_rd_addr(rq_addr[2]),
        .u_rd_rdy(u_rd_rdy), .u_ret_valid(u_ret_valid), .u_ret_last(u_ret_last),
        .ret_data(ret_data),
        .d_wr_req(rq_req[3]), .d_wr_type(rq_type[3]), .d_wr_addr(rq_addr[3]),
        .d_wr_wstrb(rq_wstrb[3]), .d_wr_data(rq_data[3]), .d_wr_rdy(d_wr_rdy),
        .u_wr_req(rq_req[4]), .u_wr_type(rq_type[4]), .u_wr_addr(rq_addr[4]),
        .u_wr_wstrb(rq_wstrb[4]), .u_wr_data(rq_data[4]), .u_wr_rdy(u_wr_rdy),
        .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr),
        .m_rd_rdy(m_rd_rdy), .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last),
        .m_ret_data(m_ret_data),
        .m_wr_req(m_wr_req), .m_wr_type(m_wr_type), .m_wr_addr(m_wr_addr),
        .m_wr_wstrb(m_wr_wstrb), .m_wr_data(m_wr_data), .m_wr_rdy(m_wr_rdy),
        .m_wr_done(m_wr_done)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    typedef struct { logic [2:0] t; logic [31:0] a; } rd_exp_t;
    typedef struct { logic [2:0] t; logic [31:0] a; logic [3:0] s; logic [LINE_W-1:0] d; } wr_exp_t;
    typedef struct { int own; logic [31:0] d; logic l; } ret_exp_t;

    rd_exp_t  rd_q[$];
    wr_exp_t  wr_q[$];
    ret_exp_t ret_q[$];

    // reference model state: phase 0 free, 1 waiting for bridge accept, 2 response
    int rd_phase, rd_own, wr_phase, wr_own, starve, beats, rd_done_cnt;
    logic [31:0] wr_addr;

    int n_vec, n_err;
    bit req_en, br_en, mon_en;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'h0000_1000 | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
        return a;
    endfunction

    function automatic logic hazard(input logic [31:0] a);
        return RAW_EN && (wr_phase != 0) && (a[31:5] == wr_addr[31:5]);
    endfunction

    task automatic model_reset();
        rd_phase = 0; rd_own = 0; wr_phase = 0; wr_own = 0;
        starve = 0; beats = 0; wr_addr = '0;
        rd_q.delete(); wr_q.delete(); ret_q.delete();
        for (int r = 0; r < 5; r++) begin
            rq_req[r] = 1'b0; gnt_seen[r] = 1'b0;
        end
        m_rd_rdy = 1'b0; m_ret_valid = 1'b0; m_ret_last = 1'b0; m_ret_data = '0;
        m_wr_rdy = 1'b0; m_wr_done = 1'b0;
    endtask

    task automatic new_request(input int r);
        rq_req[r]   = 1'b1;
        rq_type[r]  = 3'($urandom);
        rq_addr[r]  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : rnd_addr();
        rq_wstrb[r] = 4'($urandom);
        for (int k = 0; k < LINE_W / 32; k++) rq_data[r][k*32 +: 32] = $urandom;
    endtask

    // requesters and bridge, driven just after each rising edge
    always begin
        @(posedge aclk);
        #1;
        if (br_en) begin
            for (int r = 0; r < 5; r++) begin
                if (rq_req[r] && gnt_seen[r]) begin
                    rq_req[r] = 1'b0;
                    gnt_seen[r] = 1'b0;
                end else if (req_en && rq_req[r] && $urandom_range(0, 63) == 0) begin
                    rq_req[r] = 1'b0;
                end
                if (req_en && !rq_req[r] && $urandom_range(0, 2) == 0) new_request(r);
            end
            m_rd_rdy   = ($urandom_range(0, 2) != 0);
            m_ret_data = $urandom;
            if (rd_phase == 2) begin
                m_ret_valid = ($urandom_range(0, 3) != 0);
                m_ret_last  = ($urandom_range(0, 5) == 0);
                if (m_ret_valid) ret_q.push_back('{rd_own, m_ret_data, m_ret_last});
            end else begin
                m_ret_valid = ($urandom_range(0, 7) == 0);
                m_ret_last  = 1'($urandom_range(0, 1));
            end
            m_wr_rdy  = 1'($urandom_range(0, 1));
            m_wr_done = (wr_phase == 2) && ($urandom_range(0, 2) == 0);
        end
    end

    // monitor: compare against the model, then advance the model
    always @(negedge aclk) begin : monitor
        int eg, ag, ewg, awg;
        logic ie, de, ue;
        logic [2:0] exp_v;
        rd_exp_t re;
        wr_exp_t we;
        ret_exp_t rt;
        if (aresetn && mon_en) begin
            eg = -1;
            if (rd_phase == 0) begin
                ie = rq_req[0] && !hazard(rq_addr[0]);
                de = rq_req[1] && !hazard(rq_addr[1]);
                ue = rq_req[2] && !((wr_phase != 0) && (wr_own == 4));
                if (ie && starve == STARVE_MAX) eg = 0;
                else if (ue) eg = 2;
                else if (de) eg = 1;
                else if (ie) eg = 0;
            end
            chk("rd_grant", {u_rd_rdy, d_rd_rdy, i_rd_rdy}, (eg < 0) ? 3'b000 : 3'(1 << eg));

            ewg = -1;
            if (wr_phase == 0) begin
                if (rq_req[4]) ewg = 4;
                else if (rq_req[3]) ewg = 3;
            end
            chk("wr_grant", {u_wr_rdy, d_wr_rdy}, (ewg < 0) ? 2'b00 : 2'(1 << (ewg - 3)));

            chk("m_rd_req", m_rd_req, rd_phase == 1);
            chk("m_wr_req", m_wr_req, wr_phase == 1);

            if (ret_q.size() > 0) begin
                rt = ret_q.pop_front();
                exp_v = 3'(1 << rt.own);
                chk("ret_valid", {u_ret_valid, d_ret_valid, i_ret_valid}, exp_v);
                chk("ret_last", {u_ret_last, d_ret_last, i_ret_last}, rt.l ? exp_v : 3'b000);
                chk("ret_data", ret_data, rt.d);
                beats++;
            end else begin
                chk("ret_idle", {u_ret_valid, d_ret_valid, i_ret_valid, u_ret_last, d_ret_last, i_ret_last}, 6'b0);
            end

            ag = -1;
            if (i_rd_rdy && rq_req[0]) ag = 0;
            else if (d_rd_rdy && rq_req[1]) ag = 1;
            else if (u_rd_rdy && rq_req[2]) ag = 2;
            if (!rq_req[0] || ag == 0) starve = 0;
            else if (ag > 0 && starve < STARVE_MAX) starve++;
            if (ag >= 0) begin
                rd_q.push_back('{rq_type[ag], rq_addr[ag]});
                gnt_seen[ag] = 1'b1;
                rd_phase = 1; rd_own = ag; beats = 0;
            end else if (rd_phase == 1 && m_rd_rdy) begin
                if (rd_q.size() == 0) begin
                    chk("rd_q_empty", 1'b1, 1'b0);
                end else begin
                    re = rd_q.pop_front();
                    chk("m_rd_type_addr", {m_rd_type, m_rd_addr}, {re.t, re.a});
                end
                rd_phase = 2;
            end else if (rd_phase == 2 && m_ret_valid && m_ret_last) begin
                rd_phase = 0;
                rd_done_cnt++;
            end

            awg = -1;
            if (u_wr_rdy && rq_req[4]) awg = 4;
            else if (d_wr_rdy && rq_req[3]) awg = 3;
            if (awg >= 0) begin
                wr_q.push_back('{rq_type[awg], rq_addr[awg], rq_wstrb[awg],
                                 (awg == 4) ? {{(LINE_W-32){1'b0}}, rq_data[4][31:0]} : rq_data[3]});
                gnt_seen[awg] = 1'b1;
                wr_phase = 1; wr_own = awg; wr_addr = rq_addr[awg];
            end else if (wr_phase == 1 && m_wr_rdy) begin
                if (wr_q.size() == 0) begin
                    chk("wr_q_empty", 1'b1, 1'b0);
                end else begin
                    we = wr_q.pop_front();
                    chk("m_wr_hdr", {m_wr_type, m_wr_addr, m_wr_wstrb}, {we.t, we.a, we.s});
                    chk("m_wr_data", m_wr_data, we.d);
                end
                wr_phase = 2;
            end else if (wr_phase == 2 && m_wr_done) begin
                wr_phase = 0;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {i_rd_rdy, d_rd_rdy, u_rd_rdy, d_wr_rdy, u_wr_rdy,
                            i_ret_valid, d_ret_valid, u_ret_valid, i_ret_last, d_ret_last,
                            u_ret_last, m_rd_req, m_wr_req}, 13'b0);
        chk({tag, "_mrd"}, {m_rd_type, m_rd_addr, ret_data}, 67'b0);
        chk({tag, "_mwr"}, {m_wr_type, m_wr_addr, m_wr_wstrb}, 39'b0);
        chk({tag, "_mwdata"}, m_wr_data, '0);
    endtask

    initial begin : main
        bit found;
        int start_done;
        n_vec = 0; n_err = 0; rd_done_cnt = 0;
        req_en = 1'b0; br_en = 1'b0; mon_en = 1'b0;
        for (int r = 0; r < 5; r++) begin
            rq_type[r] = '0; rq_addr[r] = '0; rq_wstrb[r] = '0; rq_data[r] = '0;
        end
        model_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        rq_req[0] = 1'b1; rq_req[2] = 1'b1; rq_req[4] = 1'b1;
        #1;
        chk_all_zero("reset");
        model_reset();
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        mon_en = 1'b1; br_en = 1'b1; req_en = 1'b1;

        repeat (4000) @(posedge aclk);

        // async reset while a response is being routed
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(posedge aclk);
            #2;
            if (rd_phase == 2 && beats >= 2 && m_ret_valid) found = 1'b1;
        end
        chk("reach_rresp", found, 1'b1);
        req_en = 1'b0; br_en = 1'b0; mon_en = 1'b0;
        aresetn = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        mon_en = 1'b1; br_en = 1'b1;

        // fresh icache fetch after reset
        @(posedge aclk);
        #2;
        start_done = rd_done_cnt;
        rq_req[0] = 1'b1; rq_type[0] = 3'b100; rq_addr[0] = 32'h1fc0_0000;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(posedge aclk);
            if (rd_done_cnt != start_done) found = 1'b1;
        end
        chk("post_reset_fetch", found, 1'b1);
        repeat (3) @(posedge aclk);
        mon_en = 1'b0; br_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
